// File: rtl/paralelo_serial_pkg.sv
// paralelo_serial_pkg
//   Shared definitions for the parallel-to-serial transmit stage and the
//   matching serial-to-parallel receiver: word width, the comma/idle
//   pattern and the link state encoding.
package paralelo_serial_pkg;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] IDLE_WORD = 8'hBC;

  // SYNC: alignment phase, only IDLE_WORD goes out.
  // DATA: payload accepted whenever valid is high.
  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage

// File: rtl/paralelo_serial_bit_counter_wrap.sv
// bit_counter_wrap
//   Free-running wrap-around bit counter. Flags the edge on which a new
//   word slot begins (counter value 0 before increment).
// Ports:
//   clk        bit clock
//   rst        asynchronous active-high reset, counter back to 0
//   load_edge  high while the counter is 0, so the next edge is a load edge
module bit_counter_wrap #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  output logic load_edge
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign load_edge = (count == '0);

endmodule

// File: rtl/paralelo_serial.sv
// paralelo_serial
//   Final transmit stage: serializes one parallel word per word slot,
//   MSB first, with no gap bits between words. After reset a run of
//   IDLE_WORD commas is sent so the receiver can align; afterwards payload
//   goes out when valid, IDLE_WORD otherwise.
// Ports:
//   clk_32f   serial bit clock, the only clock
//   reset     asynchronous active-high reset
//   data_in   parallel word from the upstream mux, sampled on load edges only
//   valid_in  data_in carries payload, sampled on load edges only
//   data_out  serial bit stream, MSB first
//   load      high in the cycle that carries bit 7 of each word
//   active    high once the sync phase is complete
//
// state | meaning
// SYNC  | sending SYNC_WORDS idle words, inputs ignored
// DATA  | sending payload when valid_in is high, idle word otherwise
module paralelo_serial #(
  parameter int                                        WIDTH      = paralelo_serial_pkg::WIDTH,
  parameter logic [paralelo_serial_pkg::WIDTH-1:0]     IDLE_WORD  = paralelo_serial_pkg::IDLE_WORD,
  parameter int                                        SYNC_WORDS = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             data_out,
  output logic             load,
  output logic             active
);

  import paralelo_serial_pkg::*;

  localparam int         CNT_W     = $clog2(WIDTH);
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS);

  logic             load_edge;
  logic [WIDTH-1:0] shift_reg;
  logic [3:0]       sync_cnt;
  logic [3:0]       sync_next;
  state_t           state;

  bit_counter_wrap #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk       (clk_32f),
    .rst       (reset),
    .load_edge (load_edge)
  );

  assign sync_next = sync_cnt + 4'd1;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      load      <= 1'b0;
      sync_cnt  <= '0;
      state     <= SYNC;
    end else begin
      // load lines up with the first bit of the word captured on this edge
      load <= load_edge;
      if (load_edge) begin
        shift_reg <= (state == DATA && valid_in) ? data_in : IDLE_WORD;
        if (state == SYNC) begin
          sync_cnt <= sync_next;
          // the slot captured on this edge is still idle; payload starts next slot
          if (sync_next == SYNC_LAST) begin
            state <= DATA;
          end
        end
      end else begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign data_out = shift_reg[WIDTH-1];
  assign active   = (state == DATA);

endmodule

// File: tb/tb_paralelo_serial.sv
module tb_paralelo_serial;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       dout0, load0, act0;
  logic       dout1, load1, act1;

  int errors = 0;
  int checks = 0;
  int slot   = 0;

  paralelo_serial #(.SYNC_WORDS(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (dout0),
    .load     (load0),
    .active   (act0)
  );

  paralelo_serial #(.SYNC_WORDS(1)) dut1 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (dout1),
    .load     (load1),
    .active   (act1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (slot %0d, t=%0t)", name, got, want, slot, $time);
    end
  endtask

  // Reference: slot s (0-based since reset) is idle during sync, then
  // carries the word sampled at its load edge if it was valid.
  function automatic logic [7:0] model_word(int s, int sync, logic [7:0] d, logic v);
    return (s < sync || !v) ? 8'hBC : d;
  endfunction

  // active goes high on the load edge of the last sync slot
  function automatic logic model_active(int s, int sync);
    return (s >= sync - 1);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    data_in = 8'h00;
    valid_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    chk("rst_dout", {31'b0, dout0}, 0);
    chk("rst_load", {30'b0, load0, load1}, 0);
    chk("rst_active", {30'b0, act0, act1}, 0);
    @(negedge clk_32f);
    reset = 1'b0;
    slot = 0;
  endtask

  // Sends one word slot; call just before a load edge, returns just before the next one.
  task automatic run_slot(input logic [7:0] d, input logic v, input logic [7:0] exp_main,
                          input bit use_exp, input bit sample_test, input string name);
    logic [7:0] w0, w1, e0, e1;
    int lbad0, lbad1;
    w0 = '0; w1 = '0; lbad0 = 0; lbad1 = 0;
    data_in = d;
    valid_in = v;
    e0 = use_exp ? exp_main : model_word(slot, 4, d, v);
    e1 = model_word(slot, 1, d, v);
    for (int b = 0; b < 8; b++) begin
      @(posedge clk_32f);
      #1;
      w0 = {w0[6:0], dout0};
      w1 = {w1[6:0], dout1};
      if (load0 !== (b == 0)) lbad0++;
      if (load1 !== (b == 0)) lbad1++;
      if (b == 0) begin
        chk({name, "_active4"}, {31'b0, act0}, {31'b0, model_active(slot, 4)});
        chk({name, "_active1"}, {31'b0, act1}, {31'b0, model_active(slot, 1)});
      end
      if (sample_test) begin
        if (b == 2) begin
          data_in = 8'h22;
          valid_in = 1'b1;
        end
      end else begin
        data_in = 8'($urandom_range(0, 255));
        valid_in = 1'($urandom_range(0, 1));
      end
    end
    chk({name, "_word4"}, {24'b0, w0}, {24'b0, e0});
    chk({name, "_word1"}, {24'b0, w1}, {24'b0, e1});
    chk({name, "_loadpat"}, 32'(lbad0 + lbad1), 0);
    slot++;
  endtask

  // Asserts reset while word 0xA5 is on the line, bpos cycles after its load edge.
  task automatic abort_at(input int bpos, input string name);
    logic [7:0] w;
    w = 8'hA5;
    data_in = w;
    valid_in = 1'b1;
    for (int b = 0; b <= bpos; b++) begin
      @(posedge clk_32f);
      #1;
    end
    chk({name, "_pre_dout"}, {31'b0, dout0}, {31'b0, w[7-bpos]});
    chk({name, "_pre_active"}, {30'b0, act0, act1}, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk({name, "_async_dout"}, {30'b0, dout0, dout1}, 0);
    chk({name, "_async_load"}, {30'b0, load0, load1}, 0);
    chk({name, "_async_active"}, {30'b0, act0, act1}, 0);
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    slot = 0;
  endtask

  initial begin
    reset = 1'b1;
    data_in = 8'h00;
    valid_in = 1'b0;

    tbl[0] = '{8'hA5, 1'b1, 8'hBC};
    tbl[1] = '{8'hA5, 1'b1, 8'hBC};
    tbl[2] = '{8'hA5, 1'b1, 8'hBC};
    tbl[3] = '{8'hA5, 1'b1, 8'hBC};
    tbl[4] = '{8'hA5, 1'b1, 8'hA5};
    tbl[5] = '{8'hFF, 1'b1, 8'hFF};
    tbl[6] = '{8'h00, 1'b0, 8'hBC};
    tbl[7] = '{8'h3C, 1'b1, 8'h3C};
    tbl[8] = '{8'hBC, 1'b1, 8'hBC};
    tbl[9] = '{8'h5A, 1'b0, 8'hBC};

    // idle after reset with valid low
    do_reset();
    for (int i = 0; i < 6; i++) run_slot(8'h00, 1'b0, 8'hBC, 1'b1, 1'b0, "idle");

    // table: sync ignores data, then mixed traffic
    do_reset();
    for (int i = 0; i < 10; i++) run_slot(tbl[i].data, tbl[i].valid, tbl[i].exp, 1'b1, 1'b0, "tbl");

    // randomized DATA-phase traffic against the model
    for (int i = 0; i < 30; i++)
      run_slot(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b0, "rand");

    // sampling window: data changes mid-word, only the load-edge value goes out
    run_slot(8'h11, 1'b1, 8'h11, 1'b1, 1'b1, "sample");
    run_slot(8'h44, 1'b1, 8'h44, 1'b1, 1'b0, "after_sample");

    // reset on the first bit of a word, then a full resync
    abort_at(0, "abort_b7");
    for (int i = 0; i < 6; i++) run_slot(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, "resync_a");

    // reset at bit 4 of a word, then a full resync
    abort_at(3, "abort_b4");
    for (int i = 0; i < 6; i++) run_slot(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, "resync_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
